// File: rtl/ps2_key_event_if.sv
// Event handshake bundle between the key-event FIFO and its CPU-side consumer.
interface ps2_key_event_if;
    logic       evt_valid;
    logic       evt_ready;
    logic [7:0] evt_code;
    logic       evt_ext;
    logic       evt_release;
    logic [7:0] evt_ascii;

    modport master (
        output evt_valid, evt_code, evt_ext, evt_release, evt_ascii,
        input  evt_ready
    );

    modport slave (
        input  evt_valid, evt_code, evt_ext, evt_release, evt_ascii,
        output evt_ready
    );
endinterface

// File: rtl/ps2_key_event.sv
// Resolves PS/2 Set-2 scan-code prefixes into key events with modifier tracking and
// ASCII translation, queued in a show-ahead FIFO behind a valid/ready port.
module ps2_key_event #(
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [7:0]      code,
    input  logic            code_valid,
    ps2_key_event_if.master evt,
    output logic [2:0]      mods,
    output logic            overflow
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXT,
        S_REL,
        S_EXTREL,
        S_SKIP
    } state_t;

    state_t             state;
    logic [2:0]         skip_cnt;
    logic [TMR_W-1:0]   timer;

    logic               emit_now;
    logic               ext_now;
    logic               rel_now;
    logic [7:0]         ascii_now;
    logic               is_noise;

    logic               ev_valid_q;
    logic [7:0]         ev_code_q;
    logic               ev_ext_q;
    logic               ev_rel_q;
    logic [7:0]         ev_ascii_q;

    logic               lshift, rshift, lctrl, rctrl, caps;

    logic [17:0]        mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               full, pop, do_wr;

    function automatic logic [7:0] ascii_of(input logic [7:0] c, input logic sh,
                                            input logic cl, input logic ct);
        logic [7:0] letter;
        logic [7:0] digit;
        logic [7:0] res;
        letter = 8'h00;
        digit  = 8'h00;
        res    = 8'h00;
        case (c)
            8'h1C: letter = "a"; 8'h32: letter = "b"; 8'h21: letter = "c";
            8'h23: letter = "d"; 8'h24: letter = "e"; 8'h2B: letter = "f";
            8'h34: letter = "g"; 8'h33: letter = "h"; 8'h43: letter = "i";
            8'h3B: letter = "j"; 8'h42: letter = "k"; 8'h4B: letter = "l";
            8'h3A: letter = "m"; 8'h31: letter = "n"; 8'h44: letter = "o";
            8'h4D: letter = "p"; 8'h15: letter = "q"; 8'h2D: letter = "r";
            8'h1B: letter = "s"; 8'h2C: letter = "t"; 8'h3C: letter = "u";
            8'h2A: letter = "v"; 8'h1D: letter = "w"; 8'h22: letter = "x";
            8'h35: letter = "y"; 8'h1A: letter = "z";
            8'h45: digit = "0";  8'h16: digit = "1";  8'h1E: digit = "2";
            8'h26: digit = "3";  8'h25: digit = "4";  8'h2E: digit = "5";
            8'h36: digit = "6";  8'h3D: digit = "7";  8'h3E: digit = "8";
            8'h46: digit = "9";
            8'h29: res = 8'h20;
            8'h5A: res = 8'h0D;
            8'h66: res = 8'h08;
            8'h0D: res = 8'h09;
            8'h76: res = 8'h1B;
            default: res = 8'h00;
        endcase
        if (letter != 8'h00) begin
            if (ct)
                res = letter & 8'h1F;
            else if (sh ^ cl)
                res = letter - 8'h20;
            else
                res = letter;
        end else if (digit != 8'h00) begin
            res = sh ? 8'h00 : digit;
        end
        return res;
    endfunction

    assign is_noise = (code == 8'hFA) || (code == 8'hAA) || (code == 8'hEE) ||
                      (code == 8'hFE) || (code == 8'h00) || (code == 8'hFF);

    // Decode whether the byte arriving now completes an event, and its flavour.
    always_comb begin
        emit_now = 1'b0;
        ext_now  = 1'b0;
        rel_now  = 1'b0;
        if (code_valid) begin
            case (state)
                S_IDLE:   emit_now = (code != 8'hE0) && (code != 8'hF0) &&
                                     (code != 8'hE1) && !is_noise;
                S_EXT: begin
                    emit_now = (code != 8'hF0) && (code != 8'hE0);
                    ext_now  = 1'b1;
                end
                S_REL: begin
                    emit_now = (code != 8'hF0);
                    rel_now  = 1'b1;
                end
                S_EXTREL: begin
                    emit_now = 1'b1;
                    ext_now  = 1'b1;
                    rel_now  = 1'b1;
                end
                default: emit_now = 1'b0;
            endcase
        end
        ascii_now = (emit_now && !ext_now && !rel_now) ?
                    ascii_of(code, lshift | rshift, caps, lctrl | rctrl) : 8'h00;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            skip_cnt <= '0;
            timer    <= '0;
        end else if (code_valid) begin
            timer <= '0;
            case (state)
                S_IDLE: begin
                    if (code == 8'hE0)
                        state <= S_EXT;
                    else if (code == 8'hF0)
                        state <= S_REL;
                    else if (code == 8'hE1) begin
                        state    <= S_SKIP;
                        skip_cnt <= 3'd7;
                    end
                end
                S_EXT: begin
                    if (code == 8'hF0)
                        state <= S_EXTREL;
                    else if (code != 8'hE0)
                        state <= S_IDLE;
                end
                S_REL:    if (code != 8'hF0) state <= S_IDLE;
                S_EXTREL: state <= S_IDLE;
                S_SKIP: begin
                    skip_cnt <= skip_cnt - 3'd1;
                    if (skip_cnt == 3'd1)
                        state <= S_IDLE;
                end
                default:  state <= S_IDLE;
            endcase
        end else if (state != S_IDLE) begin
            if (timer == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                state <= S_IDLE;
                timer <= '0;
            end else begin
                timer <= timer + TMR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ev_valid_q <= 1'b0;
            ev_code_q  <= '0;
            ev_ext_q   <= 1'b0;
            ev_rel_q   <= 1'b0;
            ev_ascii_q <= '0;
        end else begin
            ev_valid_q <= emit_now;
            if (emit_now) begin
                ev_code_q  <= code;
                ev_ext_q   <= ext_now;
                ev_rel_q   <= rel_now;
                ev_ascii_q <= ascii_now;
            end
        end
    end

    // Modifiers change with the emitting byte, so they are live one cycle before the event is queued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lshift <= 1'b0;
            rshift <= 1'b0;
            lctrl  <= 1'b0;
            rctrl  <= 1'b0;
            caps   <= 1'b0;
        end else if (emit_now) begin
            case (code)
                8'h12: lshift <= !rel_now;
                8'h59: rshift <= !rel_now;
                8'h14: begin
                    if (ext_now)
                        rctrl <= !rel_now;
                    else
                        lctrl <= !rel_now;
                end
                8'h58: if (!ext_now && !rel_now) caps <= ~caps;
                default: ;
            endcase
        end
    end

    assign mods = {caps, lctrl | rctrl, lshift | rshift};

    assign full  = (count == CNT_W'(FIFO_DEPTH));
    assign pop   = evt.evt_valid && evt.evt_ready;
    assign do_wr = ev_valid_q && (!full || pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++)
                mem[i] <= '0;
        end else begin
            overflow <= ev_valid_q && full && !pop;
            if (do_wr) begin
                mem[wr_ptr] <= {ev_code_q, ev_ext_q, ev_rel_q, ev_ascii_q};
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_wr, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign evt.evt_valid   = (count != '0);
    assign evt.evt_code    = mem[rd_ptr][17:10];
    assign evt.evt_ext     = mem[rd_ptr][9];
    assign evt.evt_release = mem[rd_ptr][8];
    assign evt.evt_ascii   = mem[rd_ptr][7:0];

endmodule

// File: tb/tb_ps2_key_event.sv
// Randomized and directed bench for ps2_key_event against a byte-stream reference model.
module tb_ps2_key_event;

    localparam int DEPTH = 4;
    localparam int TO    = 20;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] code;
    logic       code_valid;
    logic [2:0] mods;
    logic       overflow;

    ps2_key_event_if evt_if ();

    ps2_key_event #(
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .code       (code),
        .code_valid (code_valid),
        .evt        (evt_if),
        .mods       (mods),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned ovf_seen = 0;

    // Reference model state: prefix flags, queued events, held keys.
    logic [17:0] mq[$];
    logic [17:0] dut_log[$];
    logic [17:0] m_pend;
    bit          m_pend_v;
    bit          m_ovf;
    bit          ext_p, rel_p;
    int          skip_left;
    int          m_idle;
    bit          h_lsh, h_rsh, h_lct, h_rct, h_caps;

    logic [7:0] letter_codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
                                      8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31,
                                      8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C,
                                      8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    logic [7:0] digit_codes [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36,
                                     8'h3D, 8'h3E, 8'h46};
    logic [7:0] pool [24] = '{8'h1C, 8'h32, 8'h21, 8'h12, 8'h59, 8'h14, 8'h58, 8'h45,
                              8'h16, 8'h29, 8'h5A, 8'h66, 8'h0D, 8'h76, 8'hE0, 8'hF0,
                              8'hE1, 8'h75, 8'hAA, 8'hFA, 8'h1A, 8'h3D, 8'h4D, 8'h12};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] model_ascii(input logic [7:0] b);
        bit sh;
        sh = h_lsh | h_rsh;
        for (int i = 0; i < 26; i++)
            if (letter_codes[i] == b) begin
                if (h_lct | h_rct) return 8'(i + 1);
                return (sh ^ h_caps) ? 8'(8'h41 + i) : 8'(8'h61 + i);
            end
        for (int d = 0; d < 10; d++)
            if (digit_codes[d] == b) return sh ? 8'h00 : 8'(8'h30 + d);
        case (b)
            8'h29:   return 8'h20;
            8'h5A:   return 8'h0D;
            8'h66:   return 8'h08;
            8'h0D:   return 8'h09;
            8'h76:   return 8'h1B;
            default: return 8'h00;
        endcase
    endfunction

    task automatic model_emit(input logic [7:0] b, input bit ext, input bit rel);
        logic [7:0] a;
        a = (!ext && !rel) ? model_ascii(b) : 8'h00;
        m_pend   = {b, ext, rel, a};
        m_pend_v = 1;
        if (b == 8'h12) h_lsh = !rel;
        if (b == 8'h59) h_rsh = !rel;
        if (b == 8'h14 && !ext) h_lct = !rel;
        if (b == 8'h14 && ext) h_rct = !rel;
        if (b == 8'h58 && !ext && !rel) h_caps = !h_caps;
        ext_p = 0;
        rel_p = 0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        bit noise;
        noise = (b == 8'hFA) || (b == 8'hAA) || (b == 8'hEE) || (b == 8'hFE) ||
                (b == 8'h00) || (b == 8'hFF);
        m_idle = 0;
        if (skip_left > 0)
            skip_left--;
        else if (!ext_p && !rel_p) begin
            if (b == 8'hE0) ext_p = 1;
            else if (b == 8'hF0) rel_p = 1;
            else if (b == 8'hE1) skip_left = 7;
            else if (!noise) model_emit(b, 0, 0);
        end else if (ext_p && rel_p)
            model_emit(b, 1, 1);
        else if (rel_p) begin
            if (b != 8'hF0) model_emit(b, 0, 1);
        end else begin
            if (b == 8'hF0) rel_p = 1;
            else if (b != 8'hE0) model_emit(b, 1, 0);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        m_pend_v  = 0;
        m_ovf     = 0;
        ext_p     = 0;
        rel_p     = 0;
        skip_left = 0;
        m_idle    = 0;
        h_lsh = 0; h_rsh = 0; h_lct = 0; h_rct = 0; h_caps = 0;
    endtask

    function automatic logic [17:0] dut_head();
        return {evt_if.evt_code, evt_if.evt_ext, evt_if.evt_release, evt_if.evt_ascii};
    endfunction

    task automatic step(input bit v, input logic [7:0] b, input bit rdy);
        code              = b;
        code_valid        = v;
        evt_if.evt_ready  = rdy;
        @(negedge clk);
        if (evt_if.evt_valid && evt_if.evt_ready) dut_log.push_back(dut_head());
        @(posedge clk);
        m_ovf = 0;
        if (rdy && mq.size() > 0) void'(mq.pop_front());
        if (m_pend_v) begin
            if (mq.size() < DEPTH) mq.push_back(m_pend);
            else m_ovf = 1;
        end
        m_pend_v = 0;
        if (v) model_byte(b);
        else if (ext_p || rel_p || skip_left > 0) begin
            m_idle++;
            if (m_idle == TO) begin
                ext_p = 0; rel_p = 0; skip_left = 0; m_idle = 0;
            end
        end
        #1;
        check_eq("evt_valid", 32'(evt_if.evt_valid), 32'(mq.size() > 0));
        if (mq.size() > 0) check_eq("head", 32'(dut_head()), 32'(mq[0]));
        check_eq("mods", 32'(mods), 32'({h_caps, h_lct | h_rct, h_lsh | h_rsh}));
        check_eq("overflow", 32'(overflow), 32'(m_ovf));
        if (overflow) ovf_seen++;
    endtask

    task automatic send(input logic [7:0] b);
        step(1, b, 1);
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(0, 8'h00, rdy);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        model_clear();
        check_eq("rst_valid", 32'(evt_if.evt_valid), 32'd0);
        check_eq("rst_mods", 32'(mods), 32'd0);
        check_eq("rst_ovf", 32'(overflow), 32'd0);
        code_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit rdy;
        rst_n            = 1'b0;
        code             = 8'h00;
        code_valid       = 1'b0;
        evt_if.evt_ready = 1'b0;
        model_clear();
        #1;
        check_eq("reset_valid", 32'(evt_if.evt_valid), 32'd0);
        check_eq("reset_evt", 32'(dut_head()), 32'd0);
        check_eq("reset_mods", 32'(mods), 32'd0);
        check_eq("reset_ovf", 32'(overflow), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        dut_log.delete();
        send(8'h1C); idle(4, 1);
        send(8'hF0); send(8'h1C); idle(4, 1);
        check_eq("n_1c", 32'(dut_log.size()), 32'd2);
        if (dut_log.size() == 2) begin
            check_eq("press_1c", 32'(dut_log[0]), 32'({8'h1C, 1'b0, 1'b0, 8'h61}));
            check_eq("rel_1c", 32'(dut_log[1]), 32'({8'h1C, 1'b0, 1'b1, 8'h00}));
        end

        dut_log.delete();
        send(8'h12);
        check_eq("shift_on", 32'(mods), 32'd1);
        send(8'h1C); send(8'hF0); send(8'h12);
        check_eq("shift_off", 32'(mods), 32'd0);
        send(8'h1C); idle(4, 1);
        check_eq("n_shift", 32'(dut_log.size()), 32'd4);
        if (dut_log.size() == 4) begin
            check_eq("upper_a", 32'(dut_log[1][7:0]), 32'h41);
            check_eq("lower_a", 32'(dut_log[3][7:0]), 32'h61);
        end

        dut_log.delete();
        send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75); idle(4, 1);
        check_eq("n_ext", 32'(dut_log.size()), 32'd2);
        if (dut_log.size() == 2) begin
            check_eq("ext_press", 32'(dut_log[0]), 32'({8'h75, 1'b1, 1'b0, 8'h00}));
            check_eq("ext_rel", 32'(dut_log[1]), 32'({8'h75, 1'b1, 1'b1, 8'h00}));
        end

        dut_log.delete();
        send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
        send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
        send(8'h29); idle(4, 1);
        check_eq("n_pause", 32'(dut_log.size()), 32'd1);
        if (dut_log.size() == 1)
            check_eq("pause_next", 32'(dut_log[0]), 32'({8'h29, 1'b0, 1'b0, 8'h20}));

        dut_log.delete();
        send(8'hE0); idle(TO, 1); send(8'h1C); idle(4, 1);
        send(8'hE0); idle(TO - 1, 1); send(8'h1C); idle(4, 1);
        check_eq("n_timeout", 32'(dut_log.size()), 32'd2);
        if (dut_log.size() == 2) begin
            check_eq("timeout_hit", 32'(dut_log[0][9]), 32'd0);
            check_eq("timeout_miss", 32'(dut_log[1][9]), 32'd1);
        end

        dut_log.delete();
        ovf_seen = 0;
        step(1, 8'h1C, 0); step(1, 8'h32, 0); step(1, 8'h21, 0);
        step(1, 8'h23, 0); step(1, 8'h24, 0); idle(3, 0);
        check_eq("ovf_pulses", 32'(ovf_seen), 32'd1);
        idle(6, 1);
        check_eq("n_drain", 32'(dut_log.size()), 32'd4);
        if (dut_log.size() == 4) begin
            check_eq("drain0", 32'(dut_log[0][17:10]), 32'h1C);
            check_eq("drain1", 32'(dut_log[1][17:10]), 32'h32);
            check_eq("drain2", 32'(dut_log[2][17:10]), 32'h21);
            check_eq("drain3", 32'(dut_log[3][17:10]), 32'h23);
        end

        // Full FIFO: the fifth event's write lands on the same edge as a pop.
        ovf_seen = 0;
        step(1, 8'h1C, 0); step(1, 8'h32, 0); step(1, 8'h21, 0); step(1, 8'h23, 0);
        idle(2, 0);
        step(1, 8'h2B, 0); step(0, 8'h00, 1); idle(6, 1);
        check_eq("full_pushpop_ovf", 32'(ovf_seen), 32'd0);

        step(1, 8'h58, 0); step(1, 8'h1C, 0); step(1, 8'hE0, 0); step(1, 8'hF0, 0);
        do_reset();
        idle(3, 1);

        for (int i = 0; i < 1500; i++) begin
            rdy = ($urandom_range(0, 9) < 7);
            if (i == 700)
                do_reset();
            else if ($urandom_range(0, 99) == 0)
                idle(TO + 2, rdy);
            else if ($urandom_range(0, 1) == 1)
                step(1, pool[$urandom_range(0, 23)], rdy);
            else
                step(0, 8'h00, rdy);
        end
        idle(8, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
